regfile_mp_sb: RTL and testbench

- Parametrised multi-port integer register file with an integrated busy-bit scoreboard.
- Provides NR_READ combinational read ports and NR_WRITE synchronous write ports.
- Optional write-to-read bypass; x0 optionally hardwired to zero.
- Sits between decode (reads, reservations) and writeback (writes, busy clear) in the LemonPC core.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_scoreboard.sv | 60 ++++++
 rtl/regfile_mp_sb.sv | 117 +++++++++++
 tb/tb_regfile_mp_sb.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the regfile_mp_sb register file and its busy-bit scoreboard.
package regfile_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 5;
   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned REG_ZERO       = 0;

   typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by reservations and cleared by writeback/flush.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned NR_READ    = 2,
   parameter int unsigned NR_WRITE   = 1,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NR_READ*ADDR_WIDTH-1:0]  rd_addr,
   output logic [NR_READ-1:0]             rd_busy,
   input  logic [NR_WRITE-1:0]            wr_en,
   input  logic [NR_WRITE*ADDR_WIDTH-1:0] wr_addr,
   input  logic                           resv_en,
   input  logic [ADDR_WIDTH-1:0]          resv_addr,
   input  logic                           flush
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Order matters: flush, then writeback clears, then the new reservation wins.
   always_comb begin
      busy_d = busy_q;
      if (flush) begin
         busy_d = '0;
      end
      for (int w = 0; w < NR_WRITE; w++) begin
         if (wr_en[w]) begin
            busy_d[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
         end
      end
      if (resv_en) begin
         busy_d[resv_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_d[REG_ZERO] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   always_comb begin
      rd_busy = '0;
      for (int i = 0; i < NR_READ; i++) begin
         rd_busy[i] = busy_q[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
      end
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-to-read bypass and integrated busy-bit scoreboard.
// Define REGFILE_TRACE_EN to print committed writes, reservations and flushes each cycle.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned NR_READ    = 2,
   parameter int unsigned NR_WRITE   = 1,
   parameter int unsigned ZERO_REG   = 1,
   parameter int unsigned BYPASS     = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NR_READ*ADDR_WIDTH-1:0]  rd_addr,
   output logic [NR_READ*DATA_WIDTH-1:0]  rd_data,
   output logic [NR_READ-1:0]             rd_busy,
   input  logic [NR_WRITE-1:0]            wr_en,
   input  logic [NR_WRITE*ADDR_WIDTH-1:0] wr_addr,
   input  logic [NR_WRITE*DATA_WIDTH-1:0] wr_data,
   input  logic                           resv_en,
   input  logic [ADDR_WIDTH-1:0]          resv_addr,
   input  logic                           flush
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] rf_q [DEPTH];
   logic [NR_READ-1:0]    sb_busy;
   logic [ADDR_WIDTH-1:0] raddr;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rbusy;

   function automatic logic is_zero_idx(input logic [ADDR_WIDTH-1:0] idx);
      return (ZERO_REG != 0) && (idx == ADDR_WIDTH'(REG_ZERO));
   endfunction

   regfile_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NR_READ    (NR_READ),
      .NR_WRITE   (NR_WRITE),
      .ZERO_REG   (ZERO_REG)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr   (rd_addr),
      .rd_busy   (sb_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .resv_en   (resv_en),
      .resv_addr (resv_addr),
      .flush     (flush)
   );

   // Ports are visited in ascending order so the highest-numbered port's NBA lands last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < DEPTH; r++) begin
            rf_q[r] <= '0;
         end
      end else begin
         for (int w = 0; w < NR_WRITE; w++) begin
            if (wr_en[w] && !is_zero_idx(wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH])) begin
               rf_q[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      raddr   = '0;
      rdata   = '0;
      rbusy   = 1'b0;
      for (int i = 0; i < NR_READ; i++) begin
         raddr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         rdata = rf_q[raddr];
         rbusy = sb_busy[i];
         if (BYPASS != 0) begin
            for (int w = 0; w < NR_WRITE; w++) begin
               if (wr_en[w] && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == raddr)) begin
                  rdata = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                  rbusy = 1'b0;
               end
            end
         end
         if (is_zero_idx(raddr) || !rst_n) begin
            rdata = '0;
            rbusy = 1'b0;
         end
         rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
         rd_busy[i]                          = rbusy;
      end
   end

`ifdef REGFILE_TRACE_EN
   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int w = 0; w < NR_WRITE; w++) begin
            if (wr_en[w] && !is_zero_idx(wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH])) begin
               $display("[regfile] write port %0d x%0d = 0x%h", w,
                        wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH], wr_data[w*DATA_WIDTH +: DATA_WIDTH]);
            end
         end
         if (flush) begin
            $display("[regfile] flush busy bits");
         end
         if (resv_en && !is_zero_idx(resv_addr)) begin
            $display("[regfile] reserve x%0d", resv_addr);
         end
      end
   end
`else
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench: table-driven vectors through a scoreboard queue plus a mid-cycle reset.
module tb_regfile_mp_sb;

   logic        clk;
   logic        rst_n;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic [63:0] nb_rd_data;
   logic [1:0]  nb_rd_busy;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        resv_en;
   logic [4:0]  resv_addr;
   logic        flush;

   int tests;
   int failed;

   regfile_mp_sb #(
      .ADDR_WIDTH (5),
      .DATA_WIDTH (32),
      .NR_READ    (2),
      .NR_WRITE   (2),
      .ZERO_REG   (1),
      .BYPASS     (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .resv_en   (resv_en),
      .resv_addr (resv_addr),
      .flush     (flush)
   );

   regfile_mp_sb #(
      .ADDR_WIDTH (5),
      .DATA_WIDTH (32),
      .NR_READ    (2),
      .NR_WRITE   (2),
      .ZERO_REG   (1),
      .BYPASS     (0)
   ) dut_nb (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr   (rd_addr),
      .rd_data   (nb_rd_data),
      .rd_busy   (nb_rd_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .resv_en   (resv_en),
      .resv_addr (resv_addr),
      .flush     (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        resv;
      logic [4:0]  rsa;
      logic        fl;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] d0;
      logic        b0;
      logic [31:0] d1;
      logic        b1;
      logic [31:0] nd0;
      logic        nb0;
   } vec_t;

   typedef struct {
      logic [31:0] d0;
      logic        b0;
      logic [31:0] d1;
      logic        b1;
      logic [31:0] nd0;
      logic        nb0;
   } exp_t;

   localparam int NV = 21;
   vec_t vecs [NV];
   exp_t expq [$];

   function automatic vec_t mk(
      input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
      input logic [4:0] wa1, input logic [31:0] wd1,
      input logic resv, input logic [4:0] rsa, input logic fl,
      input logic [4:0] ra0, input logic [4:0] ra1,
      input logic [31:0] d0, input logic b0, input logic [31:0] d1, input logic b1,
      input logic [31:0] nd0, input logic nb0);
      vec_t v;
      v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
      v.resv = resv; v.rsa = rsa; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
      v.d0 = d0; v.b0 = b0; v.d1 = d1; v.b1 = b1; v.nd0 = nd0; v.nb0 = nb0;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      exp_t e;
      wr_en     = v.we;
      wr_addr   = {v.wa1, v.wa0};
      wr_data   = {v.wd1, v.wd0};
      resv_en   = v.resv;
      resv_addr = v.rsa;
      flush     = v.fl;
      rd_addr   = {v.ra1, v.ra0};
      e.d0 = v.d0; e.b0 = v.b0; e.d1 = v.d1; e.b1 = v.b1; e.nd0 = v.nd0; e.nb0 = v.nb0;
      expq.push_back(e);
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      tests++;
      if (expq.size() == 0) begin
         failed++;
         $display("FAIL %s queue: got empty scoreboard, expected one entry", tag);
      end else begin
         e = expq.pop_front();
         chk({tag, " d0"},    rd_data[31:0],          e.d0);
         chk({tag, " b0"},    32'(rd_busy[0]),        32'(e.b0));
         chk({tag, " d1"},    rd_data[63:32],         e.d1);
         chk({tag, " b1"},    32'(rd_busy[1]),        32'(e.b1));
         chk({tag, " nb d0"}, nb_rd_data[31:0],       e.nd0);
         chk({tag, " nb b0"}, 32'(nb_rd_busy[0]),     32'(e.nb0));
      end
   endtask

   task automatic idle();
      wr_en = '0; wr_addr = '0; wr_data = '0;
      resv_en = 1'b0; resv_addr = '0; flush = 1'b0; rd_addr = '0;
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      rst_n  = 1'b0;
      idle();

      //       we wa0 wd0           wa1 wd1      rs rsa fl ra0 ra1  d0            b0 d1            b1 nd0           nb0
      vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,  0, 0, 0, 1, 31, 32'h0,        0, 32'h0,        0, 32'h0,        0);
      vecs[1]  = mk(1, 5, 32'hDEADBEEF, 0, 32'h0,  0, 0, 0, 5, 0,  32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        0);
      vecs[2]  = mk(0, 0, 32'h0,        0, 32'h0,  0, 0, 0, 5, 5,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
      vecs[3]  = mk(1, 0, 32'h1234,     0, 32'h0,  1, 0, 0, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0,        0);
      vecs[4]  = mk(0, 0, 32'h0,        0, 32'h0,  0, 0, 0, 0, 5,  32'h0,        0, 32'hDEADBEEF, 0, 32'h0,        0);
      vecs[5]  = mk(3, 7, 32'hA,        7, 32'hB,  0, 0, 0, 7, 1,  32'hB,        0, 32'h0,        0, 32'h0,        0);
      vecs[6]  = mk(0, 0, 32'h0,        0, 32'h0,  0, 0, 0, 7, 7,  32'hB,        0, 32'hB,        0, 32'hB,        0);
      vecs[7]  = mk(1, 3, 32'h11,       0, 32'h0,  0, 0, 0, 3, 7,  32'h11,       0, 32'hB,        0, 32'h0,        0);
      vecs[8]  = mk(1, 3, 32'h22,       0, 32'h0,  0, 0, 0, 3, 3,  32'h22,       0, 32'h22,       0, 32'h11,       0);
      vecs[9]  = mk(0, 0, 32'h0,        0, 32'h0,  1, 9, 0, 9, 3,  32'h0,        0, 32'h22,       0, 32'h0,        0);
      vecs[10] = mk(0, 0, 32'h0,        0, 32'h0,  0, 0, 0, 9, 9,  32'h0,        1, 32'h0,        1, 32'h0,        1);
      vecs[11] = mk(1, 9, 32'h55,       0, 32'h0,  0, 0, 0, 9, 9,  32'h55,       0, 32'h55,       0, 32'h0,        1);
      vecs[12] = mk(0, 0, 32'h0,        0, 32'h0,  0, 0, 0, 9, 9,  32'h55,       0, 32'h55,       0, 32'h55,       0);
      vecs[13] = mk(2, 0, 32'h0,        9, 32'h66, 1, 9, 0, 9, 9,  32'h66,       0, 32'h66,       0, 32'h55,       0);
      vecs[14] = mk(0, 0, 32'h0,        0, 32'h0,  0, 0, 0, 9, 9,  32'h66,       1, 32'h66,       1, 32'h66,       1);
      vecs[15] = mk(0, 0, 32'h0,        0, 32'h0,  1, 2, 0, 2, 6,  32'h0,        0, 32'h0,        0, 32'h0,        0);
      vecs[16] = mk(0, 0, 32'h0,        0, 32'h0,  1, 6, 0, 2, 6,  32'h0,        1, 32'h0,        0, 32'h0,        1);
      vecs[17] = mk(1, 10, 32'h77,      0, 32'h0,  1, 4, 1, 2, 6,  32'h0,        1, 32'h0,        1, 32'h0,        1);
      vecs[18] = mk(0, 0, 32'h0,        0, 32'h0,  0, 0, 0, 2, 4,  32'h0,        0, 32'h0,        1, 32'h0,        0);
      vecs[19] = mk(0, 0, 32'h0,        0, 32'h0,  0, 0, 0, 6, 10, 32'h0,        0, 32'h77,       0, 32'h0,        0);
      vecs[20] = mk(0, 0, 32'h0,        0, 32'h0,  0, 0, 0, 9, 4,  32'h66,       0, 32'h0,        1, 32'h66,       0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset state across every index on both ports.
      for (int idx = 0; idx < 32; idx++) begin
         @(negedge clk);
         rd_addr = {5'(31 - idx), 5'(idx)};
         #2;
         chk($sformatf("reset d0 x%0d", idx), rd_data[31:0],  32'h0);
         chk($sformatf("reset d1 x%0d", idx), rd_data[63:32], 32'h0);
         chk($sformatf("reset b x%0d", idx),  32'(rd_busy),   32'h0);
         chk($sformatf("reset nb x%0d", idx), 32'(nb_rd_busy), 32'h0);
      end

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #2;
         check_out($sformatf("vec%0d", i));
      end

      // Asynchronous reset in the middle of a cycle that carries a write and a reservation.
      @(negedge clk);
      idle();
      wr_en     = 2'b01;
      wr_addr   = {5'd0, 5'd12};
      wr_data   = {32'h0, 32'h0000ABCD};
      resv_en   = 1'b1;
      resv_addr = 5'd13;
      rd_addr   = {5'd4, 5'd5};
      #1;
      chk("pre-reset d0 x5",   rd_data[31:0], 32'hDEADBEEF);
      chk("pre-reset b1 x4",   32'(rd_busy[1]), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("in-reset d0",       rd_data[31:0],    32'h0);
      chk("in-reset busy",     32'(rd_busy),     32'h0);
      chk("in-reset nb d0",    nb_rd_data[31:0], 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      rd_addr = {5'd13, 5'd12};
      #2;
      chk("post-reset x12 lost", rd_data[31:0], 32'h0);
      chk("post-reset x13 busy", 32'(rd_busy),  32'h0);
      @(negedge clk);
      rd_addr = {5'd10, 5'd5};
      #2;
      chk("post-reset x5",  rd_data[31:0],  32'h0);
      chk("post-reset x10", rd_data[63:32], 32'h0);

      if (expq.size() != 0) begin
         tests++;
         failed++;
         $display("FAIL scoreboard drain: got %0d entries left, expected 0", expq.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
